// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic edge feeder.
//   feeder_state_e : feeder FSM encodings (idle / stream / drain / done)
//   drain_cycles() : flush length after the last slice, from grid size and multiplier latency
//   `LANE_SLICE    : part-select of lane idx in a packed bus of w-bit lanes
// Optional feature macro used by the feeder: SKEW_FEEDER_LEN_CHECK_EN.

`ifndef LANE_SLICE
`define LANE_SLICE(idx, w) (idx)*(w) +: (w)
`endif

package systolic_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StStream = 2'd1,
        StDrain  = 2'd2,
        StDone   = 2'd3
    } feeder_state_e;

    // Skew across the grid diagonal (2*(n-1)) plus the multiplier pipe plus the accumulate.
    function automatic int unsigned drain_cycles(input int unsigned n,
                                                 input int unsigned mul_lat);
        return 2 * (n - 1) + mul_lat + 1;
    endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Zero-reset shift register for one edge lane.
// Ports:
//   clk   in             clock, all state on posedge
//   rst   in             synchronous active-high reset, clears every stage
//   din   in  DATA_WIDTH value entering the lane this cycle
//   dout  out DATA_WIDTH value leaving the last stage (DEPTH cycles after entry)

module skew_delay_line
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < int'(DEPTH); s++) begin
                stage_q[s] <= '0;
            end
        end else begin
            stage_q[0] <= din;
            for (int s = 1; s < int'(DEPTH); s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Edge transmitter for an output-stationary PE grid. Takes one k-slice per beat (column k of A,
// row k of B), skews it onto the left-column a lanes and top-row b lanes, flushes zeros after
// the last slice until the far corner PE has accumulated, then pulses done.
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready slice handshake, beat accepted when both high at posedge
//   in_last           beat is the final slice of the product
//   in_a, in_b        N lanes of DATA_WIDTH, lane i in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   a_edge, b_edge    skewed lane outputs; value accepted at edge t shows on lane i after t+i+1
//   busy              high while streaming or draining
//   done              one-cycle pulse when grid accumulation is complete
//   err_len           sticky slice-count error (only with SKEW_FEEDER_LEN_CHECK_EN)
// Build option: define SKEW_FEEDER_LEN_CHECK_EN to add the beat counter and err_len.

module systolic_skew_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned N          = 4,
    parameter int unsigned K          = 4,
    parameter int unsigned MUL_LAT    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    input  logic [N*DATA_WIDTH-1:0] in_a,
    input  logic [N*DATA_WIDTH-1:0] in_b,
    output logic [N*DATA_WIDTH-1:0] a_edge,
    output logic [N*DATA_WIDTH-1:0] b_edge,
    output logic                    busy,
    output logic                    done
`ifdef SKEW_FEEDER_LEN_CHECK_EN
    ,
    output logic                    err_len
`endif
);

    localparam int unsigned DrainCycles = drain_cycles(N, MUL_LAT);
    localparam int unsigned CntW        = $clog2(DrainCycles + 1);

    feeder_state_e   state_q, state_d;
    logic [CntW-1:0] drain_cnt_q, drain_cnt_d;
    logic            accept;

    assign accept = in_valid && in_ready;

    // ---------------------------------------------------------------- control FSM
    // The counter runs DrainCycles..0, so done lands DrainCycles+1 edges after the last beat.
    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        in_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            StIdle, StStream: begin
                in_ready = 1'b1;
                busy     = (state_q == StStream);
                if (in_valid) begin
                    if (in_last) begin
                        state_d     = StDrain;
                        drain_cnt_d = CntW'(DrainCycles);
                    end else begin
                        state_d = StStream;
                    end
                end
            end
            StDrain: begin
                busy = 1'b1;
                if (drain_cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    drain_cnt_d = drain_cnt_q - CntW'(1);
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            drain_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
        end
    end

    // ---------------------------------------------------------------- injection and skew
    // Capture register ahead of the lanes: a bubble injects zeros, whatever sits on in_a/in_b.
    logic [N*DATA_WIDTH-1:0] inj_a_q, inj_b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            inj_a_q <= '0;
            inj_b_q <= '0;
        end else begin
            inj_a_q <= accept ? in_a : '0;
            inj_b_q <= accept ? in_b : '0;
        end
    end

    for (genvar i = 0; i < int'(N); i++) begin : g_lane
        skew_delay_line #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (i + 1)
        ) u_a_line (
            .clk (clk),
            .rst (rst),
            .din (inj_a_q[`LANE_SLICE(i, DATA_WIDTH)]),
            .dout(a_edge[`LANE_SLICE(i, DATA_WIDTH)])
        );

        skew_delay_line #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (i + 1)
        ) u_b_line (
            .clk (clk),
            .rst (rst),
            .din (inj_b_q[`LANE_SLICE(i, DATA_WIDTH)]),
            .dout(b_edge[`LANE_SLICE(i, DATA_WIDTH)])
        );
    end

    // ---------------------------------------------------------------- optional length check
`ifdef SKEW_FEEDER_LEN_CHECK_EN
    localparam int unsigned BeatW = (K > 1) ? $clog2(K) : 1;

    logic [BeatW-1:0] beat_q, beat_d;
    logic             err_len_q, err_len_d;
    logic             beat_is_final;

    assign beat_is_final = (beat_q == BeatW'(K - 1));

    always_comb begin
        beat_d    = beat_q;
        err_len_d = err_len_q;
        if (accept) begin
            // Flag a last beat that is early, or a final-count beat that is not marked last.
            if (in_last != beat_is_final) begin
                err_len_d = 1'b1;
            end
            beat_d = (in_last || beat_is_final) ? '0 : beat_q + BeatW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q    <= '0;
            err_len_q <= 1'b0;
        end else begin
            beat_q    <= beat_d;
            err_len_q <= err_len_d;
        end
    end

    assign err_len = err_len_q;
`else
    // K only sizes the length check; keep it referenced so the default build elaborates it.
    if (K == 0) begin : g_k_unused
    end
`endif

endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;

    localparam int DW = 8;
    localparam int N  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] a_edge;
    logic [31:0] b_edge;
    logic        busy;
    logic        done;
`ifdef SKEW_FEEDER_LEN_CHECK_EN
    logic        err_len;
`endif

    int checks = 0;
    int errors = 0;

    // Per-cycle stimulus slots for run_seq
    logic [31:0] slot_a [8];
    logic [31:0] slot_b [8];
    bit          slot_v [8];
    bit          slot_l [8];

    always #5 clk = ~clk;

    systolic_skew_feeder #(
        .DATA_WIDTH(8),
        .N         (4),
        .K         (4),
        .MUL_LAT   (1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_last (in_last),
        .in_a    (in_a),
        .in_b    (in_b),
        .a_edge  (a_edge),
        .b_edge  (b_edge),
        .busy    (busy),
        .done    (done)
`ifdef SKEW_FEEDER_LEN_CHECK_EN
        ,
        .err_len (err_len)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected lane bus m edges after the first slot edge: lane i carries slot m-i-1.
    function automatic logic [31:0] skewed(input bit is_b, input int nslots, input int m);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            int s;
            s = m - i - 1;
            if (s >= 0 && s < nslots && slot_v[s]) begin
                r[i*DW +: DW] = is_b ? slot_b[s][i*DW +: DW] : slot_a[s][i*DW +: DW];
            end
        end
        return r;
    endfunction

    // Drives slots 0..nslots-1 on consecutive edges (last slot carries in_last), then either
    // idles or holds in_valid high; checks lanes, done, busy and in_ready after every edge.
    task automatic run_seq(input string tag, input int nslots, input int nsteps,
                           input bit hold_valid, input int err_step);
        int last;
        last = nslots - 1;
        for (int m = 0; m < nsteps; m++) begin
            if (m < nslots) begin
                in_valid = slot_v[m];
                in_last  = slot_l[m];
                in_a     = slot_a[m];
                in_b     = slot_b[m];
            end else begin
                in_valid = hold_valid;
                in_last  = hold_valid;
                in_a     = hold_valid ? 32'hdead_beef : 32'h0;
                in_b     = hold_valid ? 32'hcafe_f00d : 32'h0;
            end
            tick();
            check($sformatf("%s a_edge m=%0d", tag, m), a_edge, skewed(1'b0, nslots, m));
            check($sformatf("%s b_edge m=%0d", tag, m), b_edge, skewed(1'b1, nslots, m));
            check($sformatf("%s done m=%0d", tag, m), 32'(done), 32'(m == last + 9));
            check($sformatf("%s busy m=%0d", tag, m), 32'(busy), 32'(m <= last + 8));
            check($sformatf("%s in_ready m=%0d", tag, m), 32'(in_ready),
                  32'((m < last) || (m >= last + 10)));
`ifdef SKEW_FEEDER_LEN_CHECK_EN
            if (err_step >= 0) begin
                check($sformatf("%s err_len m=%0d", tag, m), 32'(err_len), 32'(m >= err_step));
            end
`else
            if (err_step > nsteps) begin
                $display("note: err_step ignored without length check");
            end
`endif
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_a     = '0;
        in_b     = '0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_a     = '0;
        in_b     = '0;

        // 1: reset held three cycles
        tick();
        tick();
        tick();
        check("reset a_edge", a_edge, 32'h0);
        check("reset b_edge", b_edge, 32'h0);
        check("reset in_ready", 32'(in_ready), 32'h1);
        check("reset busy", 32'(busy), 32'h0);
        check("reset done", 32'(done), 32'h0);
`ifdef SKEW_FEEDER_LEN_CHECK_EN
        check("reset err_len", 32'(err_len), 32'h0);
`endif
        rst = 1'b0;
        tick();

        // 2: single last beat, A col {4,3,2,1}, B row {8,7,6,5}
        slot_v[0] = 1'b1;
        slot_l[0] = 1'b1;
        slot_a[0] = 32'h0403_0201;
        slot_b[0] = 32'h0807_0605;
        run_seq("single", 1, 12, 1'b0, -1);

        // 3: four beats with a bubble (garbage data, valid low) between beats 1 and 2
        for (int s = 0; s < 5; s++) begin
            slot_v[s] = (s != 1);
            slot_l[s] = (s == 4);
            for (int i = 0; i < N; i++) begin
                slot_a[s][i*DW +: DW] = (s == 1) ? 8'hff : 8'(8'h10 * (s + 1) + i + 1);
                slot_b[s][i*DW +: DW] = (s == 1) ? 8'hee : 8'(8'h80 + 8'h10 * s + i + 1);
            end
        end
        run_seq("bubble", 5, 16, 1'b0, -1);

        // 4: in_valid held high through drain must not inject anything
        slot_v[0] = 1'b1;
        slot_l[0] = 1'b1;
        slot_a[0] = 32'h1122_3344;
        slot_b[0] = 32'h5566_7788;
        run_seq("hold", 1, 10, 1'b1, -1);
        tick();
        check("hold after done", 32'(done), 32'h0);
        check("hold idle in_ready", 32'(in_ready), 32'h1);
        check("hold idle a_edge", a_edge, 32'h0);

        // 5a: reset while draining, drain counter at 4
        in_valid = 1'b1;
        in_last  = 1'b0;
        in_a     = 32'h0a0b_0c0d;
        in_b     = 32'h1a1b_1c1d;
        tick();
        in_last  = 1'b1;
        in_a     = 32'h2a2b_2c2d;
        in_b     = 32'h3a3b_3c3d;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_a     = '0;
        in_b     = '0;
        for (int k = 0; k < 4; k++) tick();
        check("drain lane3 a before rst", a_edge, 32'h2a00_0000);
        check("drain lane3 b before rst", b_edge, 32'h3a00_0000);
        rst = 1'b1;
        tick();
        check("drain rst a_edge", a_edge, 32'h0);
        check("drain rst b_edge", b_edge, 32'h0);
        check("drain rst busy", 32'(busy), 32'h0);
        check("drain rst in_ready", 32'(in_ready), 32'h1);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("drain aborted done k=%0d", k), 32'(done), 32'h0);
        end

        // 5b: reset mid-stream with values still in flight
        in_valid = 1'b1;
        in_a     = 32'h4142_4344;
        in_b     = 32'h5152_5354;
        tick();
        in_a     = 32'h6162_6364;
        in_b     = 32'h7172_7374;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        tick();
        check("stream rst a_edge", a_edge, 32'h0);
        check("stream rst b_edge", b_edge, 32'h0);
        check("stream rst busy", 32'(busy), 32'h0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            check($sformatf("stream aborted a_edge k=%0d", k), a_edge, 32'h0);
        end

`ifdef SKEW_FEEDER_LEN_CHECK_EN
        // 6: in_last on beat index 2 of a K=4 product
        for (int s = 0; s < 3; s++) begin
            slot_v[s] = 1'b1;
            slot_l[s] = (s == 2);
            slot_a[s] = 32'h0101_0101 * (s + 1);
            slot_b[s] = 32'h1010_1010 * (s + 1);
        end
        run_seq("lencheck", 3, 14, 1'b0, 2);
        rst = 1'b1;
        tick();
        check("lencheck cleared by rst", 32'(err_len), 32'h0);
        rst = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
